lfsr_hex_display: RTL and testbench



---
 rtl/lfsr_hex_pkg.sv | 43 ++++
 rtl/lfsr_hex_if.sv | 15 +
 rtl/lfsr_hex_display_btn_debounce.sv | 108 ++++++++++
 rtl/lfsr_hex_display.sv | 91 +++++++++
 tb/tb_lfsr_hex_display.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/lfsr_hex_pkg.sv
// Shared encodings and the hex-to-7-segment decoder for the LFSR hex display.
package lfsr_hex_pkg;

  typedef enum logic [1:0] {
    MODE_STEP = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    DB_IDLE_LO = 2'b00,
    DB_WAIT_HI = 2'b01,
    DB_IDLE_HI = 2'b10,
    DB_WAIT_LO = 2'b11
  } db_state_e;

  // Active-low segments, bit7 = a ... bit1 = g, bit0 = dp (always off).
  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = 8'h03;
      4'h1:    code = 8'h9F;
      4'h2:    code = 8'h25;
      4'h3:    code = 8'h0D;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h49;
      4'h6:    code = 8'h41;
      4'h7:    code = 8'h1F;
      4'h8:    code = 8'h01;
      4'h9:    code = 8'h09;
      4'hA:    code = 8'h11;
      4'hB:    code = 8'hC1;
      4'hC:    code = 8'h63;
      4'hD:    code = 8'h85;
      4'hE:    code = 8'h61;
      4'hF:    code = 8'h71;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/lfsr_hex_if.sv
// Board-facing signal bundle: button/mode/seed in, LEDs/segments/pulse out.
interface lfsr_hex_if #(
  parameter int WIDTH = 8,
  parameter int NDIG  = (WIDTH + 3) / 4
);
  logic                btn;
  logic [1:0]          mode;
  logic [WIDTH-1:0]    seed;
  logic [WIDTH-1:0]    ledr;
  logic [8*NDIG-1:0]   seg;
  logic                step_pulse;

  modport master (output btn, mode, seed, input ledr, seg, step_pulse);
  modport slave  (input btn, mode, seed, output ledr, seg, step_pulse);
endinterface

// File: rtl/lfsr_hex_display_btn_debounce.sv
// Two-flop synchroniser plus a four-state debounce FSM; emits one registered
// pulse per accepted press.
module btn_debounce
  import lfsr_hex_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  // The IDLE_* cycle that spots the change counts as the first stable cycle.
  localparam bit          SHORT    = (DEBOUNCE_CYCLES <= 20'd1);
  localparam logic [19:0] CNT_LAST = SHORT ? 20'd0 : (DEBOUNCE_CYCLES - 20'd2);

  logic        sync1_q, sync2_q;
  logic [1:0]  vld_q;
  logic        armed_q;
  db_state_e   state_q;
  logic [19:0] cnt_q;
  logic        level_q, pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

  // A press only counts once a genuine low has come through the synchroniser
  // after reset, so a button held across reset cannot fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      state_q <= DB_IDLE_LO;
      cnt_q   <= 20'd0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (!armed_q && (vld_q == 2'b11) && !sync2_q) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        DB_IDLE_LO: begin
          if (armed_q && sync2_q) begin
            if (SHORT) begin
              state_q <= DB_IDLE_HI;
              level_q <= 1'b1;
              pulse_q <= 1'b1;
            end else begin
              state_q <= DB_WAIT_HI;
              cnt_q   <= 20'd0;
            end
          end
        end
        DB_WAIT_HI: begin
          if (!sync2_q) begin
            state_q <= DB_IDLE_LO;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_IDLE_HI;
            level_q <= 1'b1;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        DB_IDLE_HI: begin
          if (!sync2_q) begin
            if (SHORT) begin
              state_q <= DB_IDLE_LO;
              level_q <= 1'b0;
            end else begin
              state_q <= DB_WAIT_LO;
              cnt_q   <= 20'd0;
            end
          end
        end
        DB_WAIT_LO: begin
          if (sync2_q) begin
            state_q <= DB_IDLE_HI;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_IDLE_LO;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        default: begin
          state_q <= DB_IDLE_LO;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level      = level_q;
  assign rise_pulse = pulse_q;

endmodule

// File: rtl/lfsr_hex_display.sv
// Fibonacci LFSR stepped by a debounced button or a free-run prescaler, with
// seed load, hold, and a registered hex 7-segment readout of the state.
module lfsr_hex_display
  import lfsr_hex_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter logic [WIDTH-1:0] TAPS            = WIDTH'(8'h1D),
  parameter int               NDIG            = (WIDTH + 3) / 4,
  parameter logic [19:0]      DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [23:0]      RUN_DIV         = 24'd5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  lfsr_hex_if.slave  bus
);

  localparam int EXTW = (4 * NDIG > WIDTH) ? 4 * NDIG : WIDTH;

  logic                step_s;
  logic                db_level_s;
  logic                wrap_s;
  logic [WIDTH-1:0]    adv_s, load_s;
  logic [WIDTH-1:0]    ledr_q, ledr_d;
  logic [23:0]         presc_q, presc_d;
  logic [EXTW-1:0]     ext_s;
  logic [8*NDIG-1:0]   seg_q, seg_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (bus.btn),
    .level      (db_level_s),
    .rise_pulse (step_s)
  );

  assign wrap_s = (presc_q == (RUN_DIV - 24'd1));

  // Prescaler only runs in RUN; any other mode discards the partial count.
  always_comb begin
    presc_d = 24'd0;
    if (bus.mode == MODE_RUN) begin
      if (wrap_s) begin
        presc_d = 24'd0;
      end else begin
        presc_d = presc_q + 24'd1;
      end
    end else begin
      presc_d = 24'd0;
    end
  end

  // All-zero state would lock the shifter, so it escapes to 1.
  always_comb begin
    adv_s  = (ledr_q == {WIDTH{1'b0}}) ? WIDTH'(1'b1)
                                       : {^(ledr_q & TAPS), ledr_q[WIDTH-1:1]};
    load_s = (bus.seed == {WIDTH{1'b0}}) ? WIDTH'(1'b1) : bus.seed;
    ledr_d = ledr_q;
    case (bus.mode)
      MODE_STEP: if (step_s) ledr_d = adv_s;  else ledr_d = ledr_q;
      MODE_RUN:  if (wrap_s) ledr_d = adv_s;  else ledr_d = ledr_q;
      MODE_LOAD: if (step_s) ledr_d = load_s; else ledr_d = ledr_q;
      MODE_HOLD: ledr_d = ledr_q;
      default:   ledr_d = ledr_q;
    endcase
  end

  always_comb begin
    ext_s = EXTW'(ledr_q);
    seg_d = {NDIG{8'h03}};
    for (int k = 0; k < NDIG; k++) begin
      seg_d[8*k +: 8] = hex2seg(ext_s[4*k +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ledr_q  <= {WIDTH{1'b0}};
      presc_q <= 24'd0;
      seg_q   <= {NDIG{8'h03}};
    end else begin
      ledr_q  <= ledr_d;
      presc_q <= presc_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.ledr       = ledr_q;
  assign bus.seg        = seg_q;
  assign bus.step_pulse = step_s;

endmodule

// File: tb/tb_lfsr_hex_display.sv
// Directed bench: an 8-bit instance for the main modes and a 12-bit instance
// for wide readout and reset during a press.
module tb_lfsr_hex_display;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lfsr_hex_if #(.WIDTH(8),  .NDIG(2)) bus1 ();
  lfsr_hex_if #(.WIDTH(12), .NDIG(3)) bus2 ();

  lfsr_hex_display #(
    .WIDTH(8), .TAPS(8'h1D), .NDIG(2),
    .DEBOUNCE_CYCLES(20'd4), .RUN_DIV(24'd3)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  lfsr_hex_display #(
    .WIDTH(12), .TAPS(12'h829), .NDIG(3),
    .DEBOUNCE_CYCLES(20'd4), .RUN_DIV(24'd3)
  ) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the button for `hold` edges, release for `rel`; count pulses and note the first.
  task automatic press(input int sel, input int hold, input int rel,
                       output int np, output int first);
    logic p;
    np = 0;
    first = -1;
    if (sel == 0) bus1.btn = 1'b1; else bus2.btn = 1'b1;
    for (int i = 1; i <= hold + rel; i++) begin
      if (i == hold + 1) begin
        if (sel == 0) bus1.btn = 1'b0; else bus2.btn = 1'b0;
      end
      tick(1);
      p = (sel == 0) ? bus1.step_pulse : bus2.step_pulse;
      if (p) begin
        np++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst2_n = 1'b0;
    bus1.btn = 1'b0; bus1.mode = 2'b00; bus1.seed = 8'h00;
    bus2.btn = 1'b0; bus2.mode = 2'b00; bus2.seed = 12'h000;
    tick(3);
    rst_n = 1'b1; rst2_n = 1'b1;
    checks++; if (bus1.ledr !== 8'h00) begin errors++; $display("FAIL reset_ledr got %h want 00", bus1.ledr); end
    checks++; if (bus1.seg !== 16'h0303) begin errors++; $display("FAIL reset_seg got %h want 0303", bus1.seg); end
    checks++; if (bus1.step_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", bus1.step_pulse); end
    checks++; if (bus2.seg !== 24'h030303) begin errors++; $display("FAIL reset_seg12 got %h want 030303", bus2.seg); end
    tick(4);
  endtask

  task automatic test_step;
    logic [7:0] exp_seq [6];
    int np, first;
    exp_seq = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
    for (int i = 0; i < 6; i++) begin
      press(0, 10, 10, np, first);
      checks++; if (np !== 1) begin errors++; $display("FAIL step_npulse[%0d] got %0d want 1", i, np); end
      checks++; if (bus1.ledr !== exp_seq[i]) begin errors++; $display("FAIL step_ledr[%0d] got %h want %h", i, bus1.ledr, exp_seq[i]); end
    end
    checks++; if (bus1.seg !== 16'h0101) begin errors++; $display("FAIL step_seg got %h want 0101", bus1.seg); end
  endtask

  task automatic test_glitch;
    int np, first;
    press(0, 3, 10, np, first);
    checks++; if (np !== 0) begin errors++; $display("FAIL glitch_npulse got %0d want 0", np); end
    checks++; if (bus1.ledr !== 8'h88) begin errors++; $display("FAIL glitch_ledr got %h want 88", bus1.ledr); end
    press(0, 6, 10, np, first);
    checks++; if (np !== 1) begin errors++; $display("FAIL min_press_npulse got %0d want 1", np); end
    checks++; if (first !== 6) begin errors++; $display("FAIL min_press_latency got %0d want 6", first); end
    checks++; if (bus1.ledr !== 8'hC4) begin errors++; $display("FAIL min_press_ledr got %h want c4", bus1.ledr); end
  endtask

  task automatic test_load;
    int np, first;
    bus1.mode = 2'b10;
    bus1.seed = 8'h5A;
    tick(3);
    checks++; if (bus1.ledr !== 8'hC4) begin errors++; $display("FAIL load_nopulse_ledr got %h want c4", bus1.ledr); end
    press(0, 10, 10, np, first);
    checks++; if (bus1.ledr !== 8'h5A) begin errors++; $display("FAIL load_5a got %h want 5a", bus1.ledr); end
    bus1.seed = 8'hC4;
    press(0, 10, 10, np, first);
    checks++; if (bus1.ledr !== 8'hC4) begin errors++; $display("FAIL load_c4 got %h want c4", bus1.ledr); end
    checks++; if (bus1.seg !== 16'h6399) begin errors++; $display("FAIL load_seg got %h want 6399", bus1.seg); end
    bus1.seed = 8'h00;
    press(0, 10, 10, np, first);
    checks++; if (bus1.ledr !== 8'h01) begin errors++; $display("FAIL load_zero got %h want 01", bus1.ledr); end
  endtask

  task automatic test_run_hold;
    int np, first;
    bus1.mode = 2'b01;
    tick(2);
    checks++; if (bus1.ledr !== 8'h01) begin errors++; $display("FAIL run_c2 got %h want 01", bus1.ledr); end
    tick(1);
    checks++; if (bus1.ledr !== 8'h80) begin errors++; $display("FAIL run_c3 got %h want 80", bus1.ledr); end
    tick(3);
    checks++; if (bus1.ledr !== 8'h40) begin errors++; $display("FAIL run_c6 got %h want 40", bus1.ledr); end
    tick(2);
    bus1.mode = 2'b11;
    tick(1);
    bus1.mode = 2'b01;
    tick(2);
    checks++; if (bus1.ledr !== 8'h40) begin errors++; $display("FAIL run_discard got %h want 40", bus1.ledr); end
    tick(1);
    checks++; if (bus1.ledr !== 8'h20) begin errors++; $display("FAIL run_resume got %h want 20", bus1.ledr); end
    bus1.mode = 2'b11;
    tick(5);
    checks++; if (bus1.ledr !== 8'h20) begin errors++; $display("FAIL hold_frozen got %h want 20", bus1.ledr); end
    press(0, 10, 10, np, first);
    checks++; if (np !== 1) begin errors++; $display("FAIL hold_npulse got %0d want 1", np); end
    checks++; if (bus1.ledr !== 8'h20) begin errors++; $display("FAIL hold_press_ledr got %h want 20", bus1.ledr); end
  endtask

  task automatic test_wide;
    int np, first;
    press(1, 10, 10, np, first);
    checks++; if (bus2.ledr !== 12'h001) begin errors++; $display("FAIL wide_ledr1 got %h want 001", bus2.ledr); end
    checks++; if (bus2.seg !== 24'h03039F) begin errors++; $display("FAIL wide_seg1 got %h want 03039f", bus2.seg); end
    press(1, 10, 10, np, first);
    checks++; if (bus2.ledr !== 12'h800) begin errors++; $display("FAIL wide_ledr2 got %h want 800", bus2.ledr); end
    checks++; if (bus2.seg !== 24'h010303) begin errors++; $display("FAIL wide_seg2 got %h want 010303", bus2.seg); end
    press(1, 10, 10, np, first);
    checks++; if (bus2.seg !== 24'h630303) begin errors++; $display("FAIL wide_seg3 got %h want 630303", bus2.seg); end
  endtask

  task automatic test_reset_mid_press;
    int np, first, cnt;
    bus2.btn = 1'b1;
    tick(4);
    rst2_n = 1'b0;
    tick(2);
    checks++; if (bus2.ledr !== 12'h000) begin errors++; $display("FAIL midrst_ledr got %h want 000", bus2.ledr); end
    rst2_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus2.step_pulse) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL midrst_npulse got %0d want 0", cnt); end
    bus2.btn = 1'b0;
    tick(10);
    press(1, 10, 10, np, first);
    checks++; if (np !== 1) begin errors++; $display("FAIL midrst_repress got %0d want 1", np); end
    checks++; if (bus2.ledr !== 12'h001) begin errors++; $display("FAIL midrst_ledr2 got %h want 001", bus2.ledr); end
  endtask

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    test_reset();
    test_step();
    test_glitch();
    test_load();
    test_run_hold();
    test_wide();
    test_reset_mid_press();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
